// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
//   fsm_state_e          : 3-bit transmitter FSM state encoding
//   CeilLog2()           : ceiling log2 used to size counters
//   DEFAULT_CLKS_PER_BIT : 50 MHz clock / 115200 baud
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } fsm_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer for the UART transmitter.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : holds the counter at zero (FSM drives it while not framing)
//   tick       : high in the last clock of each CLKS_PER_BIT-cycle bit period
module baud_tick_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = CeilLog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign tick   = at_end && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (at_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter. Whenever the FIFO is non-empty it reads the
// head word, pops it, and sends start bit, DATA_WIDTH data bits LSB first,
// optional even parity bit, then STOP_BITS stop bits. tx is registered.
//   clk, reset  : system clock, synchronous active-high reset
//   fifo_data   : FIFO registered head-word output
//   fifo_empty  : FIFO empty flag
//   fifo_pop    : one-cycle pop strobe (LOAD state only)
//   tx          : serial line, idle high
//   busy        : high from WAIT through the last stop-bit cycle
//   frame_done  : pulse in the last cycle of the final stop bit
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  // Sized to also count stop bits, which never exceed two.
  localparam int BIT_W = CeilLog2(DATA_WIDTH + 1);

  fsm_state_e            state_q, state_d;
  logic                  tick, baud_clear;
  logic                  last_data, last_stop;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  tx_q, tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  assign shift_nxt = shift_q >> 1;
  assign last_data = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
  assign last_stop = (bit_cnt_q == BIT_W'(STOP_BITS - 1));
  assign tx        = tx_q;

  // tx_d is the line level for the state being entered, so the registered
  // tx changes in the same cycle the FSM changes state.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    baud_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy       = 1'b0;
        baud_clear = 1'b1;
        tx_d       = 1'b1;
        if (!fifo_empty) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Give the FIFO's registered read port a cycle to present the head.
        baud_clear = 1'b1;
        tx_d       = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        baud_clear = 1'b1;
        fifo_pop   = 1'b1;
        tx_d       = 1'b0;
        state_d    = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (last_data) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_nxt[0];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick && last_stop) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;

      if (state_q == ST_LOAD) begin
        shift_q <= fifo_data;
      end else if (state_q == ST_DATA && tick) begin
        shift_q <= shift_nxt;
      end

      // One counter serves both data bits and stop bits; any state change
      // restarts it so each phase counts from zero.
      if (state_d != state_q) begin
        bit_cnt_q <= '0;
      end else if (tick) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

`ifdef FIFO_UART_TX_PARITY_EN
      if (state_q == ST_LOAD) begin
        parity_q <= ^fifo_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_pop, tx, busy, frame_done;

  logic [7:0] fifo_data2;
  logic       fifo_empty2;
  logic       pop2, tx2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int dones = 0;
  int pop_empty_viol = 0;

  logic [7:0] q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .fifo_data(fifo_data2), .fifo_empty(fifo_empty2),
    .fifo_pop(pop2), .tx(tx2), .busy(busy2), .frame_done(done2)
  );

  // FIFO model with registered head-word output.
  initial begin
    fifo_data  = '0;
    fifo_empty = 1'b1;
  end

  always @(posedge clk) begin
    if (fifo_pop && fifo_empty) pop_empty_viol <= pop_empty_viol + 1;
    if (fifo_pop) pops <= pops + 1;
    if (frame_done) dones <= dones + 1;
    if (fifo_pop && q.size() != 0) void'(q.pop_front());
    fifo_data  <= (q.size() != 0) ? q[0] : 8'h00;
    fifo_empty <= (q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Three idle-high cycles (IDLE, WAIT, LOAD); pop only in the third.
  task automatic expect_pop3(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_gap_tx"}, tx, 1);
      chk({tag, "_gap_pop"}, fifo_pop, (i == 2) ? 1 : 0);
      chk({tag, "_gap_busy"}, busy, (i != 0) ? 1 : 0);
    end
  endtask

  task automatic wait_pop(input string tag, input int exp_cycles);
    int n;
    bit found;
    found = 0;
    n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (fifo_pop === 1'b1) found = 1;
    end
    chk({tag, "_pop_seen"}, found, 1);
    chk({tag, "_pop_lat"}, n, exp_cycles);
  endtask

  // Called at the falling edge inside the LOAD cycle.
  task automatic check_frame(input string tag, input bit sel, input logic [7:0] w,
                             input logic par, input int stops);
    logic [11:0] frame;
    int n;
    frame      = '1;
    frame[0]   = 1'b0;
    frame[8:1] = w;
`ifdef FIFO_UART_TX_PARITY_EN
    frame[9] = par;
    n = 10 + stops;
`else
    n = 9 + stops;
`endif
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk({tag, "_tx"}, sel ? tx2 : tx, frame[b]);
        chk({tag, "_done"}, sel ? done2 : frame_done, (b == n - 1 && c == CPB - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int p0, d0;
    reset       = 1'b1;
    fifo_data2  = 8'h00;
    fifo_empty2 = 1'b1;

    // 1: reset held with FIFO non-empty
    @(negedge clk);
    q.push_back(8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_pop", fifo_pop, 0);
      chk("rst_busy", busy, 0);
    end
    reset = 1'b0;
    #1;
    chk("rst_after_tx", tx, 1);
    chk("rst_after_pop", fifo_pop, 0);
    chk("rst_after_busy", busy, 0);
    wait_pop("w5a", 2);
    check_frame("f5a", 0, 8'h5A, 1'b0, 1);

    // 2: single word A5
    @(negedge clk);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    p0 = pops;
    d0 = dones;
    q.push_back(8'hA5);
    expect_pop3("a5");
    check_frame("fa5", 0, 8'hA5, 1'b0, 1);
    @(negedge clk);
    chk("a5_pops", pops - p0, 1);
    chk("a5_dones", dones - d0, 1);
    chk("a5_end_busy", busy, 0);

    // 3: back-to-back 01, 80, FF
    p0 = pops;
    q.push_back(8'h01);
    q.push_back(8'h80);
    q.push_back(8'hFF);
    expect_pop3("b01");
    check_frame("f01", 0, 8'h01, 1'b1, 1);
    expect_pop3("b80");
    check_frame("f80", 0, 8'h80, 1'b1, 1);
    expect_pop3("bff");
    check_frame("fff", 0, 8'hFF, 1'b0, 1);
    @(negedge clk);
    chk("b2b_pops", pops - p0, 3);
    chk("b2b_empty", fifo_empty, 1);

    // 4: reset in the middle of DATA for 3C, 42 left queued
    p0 = pops;
    q.push_back(8'h3C);
    q.push_back(8'h42);
    expect_pop3("r3c");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("r3c_partial_tx", tx, (i < 4) ? 0 : 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pop", fifo_pop, 0);
    chk("mid_rst_done", frame_done, 0);
    reset = 1'b0;
    wait_pop("w42", 2);
    check_frame("f42", 0, 8'h42, 1'b0, 1);
    @(negedge clk);
    chk("r3c_pops", pops - p0, 2);
    chk("r3c_empty", fifo_empty, 1);

    // 5: FIFO empty for 100 cycles
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("empty_tx", tx, 1);
      chk("empty_pop", fifo_pop, 0);
    end
    chk("empty_pops", pops - p0, 0);

    // 6: parity-sensitive words, then two stop bits on the second instance
    q.push_back(8'h07);
    q.push_back(8'h03);
    expect_pop3("p07");
    check_frame("f07", 0, 8'h07, 1'b1, 1);
    expect_pop3("p03");
    check_frame("f03", 0, 8'h03, 1'b0, 1);

    @(negedge clk);
    fifo_data2  = 8'h07;
    fifo_empty2 = 1'b0;
    @(negedge clk);
    chk("sb2_wait_busy", busy2, 1);
    chk("sb2_wait_pop", pop2, 0);
    @(negedge clk);
    chk("sb2_load_pop", pop2, 1);
    fifo_empty2 = 1'b1;
    check_frame("sb2", 1, 8'h07, 1'b1, 2);
    @(negedge clk);
    chk("sb2_end_busy", busy2, 0);
    chk("sb2_end_tx", tx2, 1);
    chk("sb2_end_pop", pop2, 0);

    chk("pop_while_empty", pop_empty_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
